conf_merge_n: RTL and testbench

- N-channel successor to the two-input mutex merge.
- Each input channel issues single-cycle drive tokens. The block arbitrates among them and forwards one drive at a time to a single downstream stage.
- It records which channel owns each outstanding drive, and routes each returning free token back to that owner.
- Supports up to DEPTH in-flight drives, selectable arbitration and error flags. Sits in the fpga_control fabric wherever several producers share one consumer.

---
 rtl/conf_merge_pkg.sv | 8 +
 rtl/conf_merge_arb.sv | 32 +++
 rtl/conf_merge_n.sv | 74 +++++++
 tb/tb_conf_merge_n.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/conf_merge_pkg.sv
// conf_merge_pkg: shared constants and width helper for the N-channel merge
package conf_merge_pkg;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
  function automatic int safe_clog2(input int v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/conf_merge_arb.sv
// conf_merge_arb: fixed-priority or round-robin arbiter over N_CH requests
module conf_merge_arb
  import conf_merge_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int IDX_W = safe_clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  i_req,
  input  logic             i_en,
  input  logic             i_mode,
  output logic             o_gnt_vld,
  output logic [IDX_W-1:0] o_gnt_idx
);
  logic [IDX_W-1:0] r_ptr;
  logic [IDX_W-1:0] w_cand [N_CH];
  for (genvar g = 0; g < N_CH; g++) begin : g_cand
    assign w_cand[g] = i_mode ? IDX_W'((int'(r_ptr) + g) % N_CH) : IDX_W'(g);
  end
  assign o_gnt_vld = i_en & |i_req;
  // candidate with the smallest search offset wins (offset = index in fixed mode)
  always_comb begin
    o_gnt_idx = '0;
    for (int k = N_CH - 1; k >= 0; k--)
      if (i_req[w_cand[k]]) o_gnt_idx = w_cand[k];
  end
  // round-robin pointer moves just past the last granted channel
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_ptr <= '0;
    else if (o_gnt_vld) r_ptr <= (o_gnt_idx == IDX_W'(N_CH - 1)) ? '0 : o_gnt_idx + 1'b1;
endmodule

// File: rtl/conf_merge_n.sv
// conf_merge_n: arbitrates N drive channels onto one consumer and routes frees back to owners
module conf_merge_n
  import conf_merge_pkg::*;
#(
  parameter int N_CH = 4,
  parameter int DEPTH = 2,
  parameter int ARB_MODE = 1,
  localparam int IDX_W = safe_clog2(N_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_CH-1:0]  i_drive,
  output logic [N_CH-1:0]  o_free,
  output logic             o_driveNext,
  output logic [IDX_W-1:0] o_sel,
  input  logic             i_freeNext,
  output logic             o_busy,
  output logic             o_err_overrun,
  output logic             o_err_spurious
);
  localparam int CW = safe_clog2(DEPTH + 1);
  localparam int PW = safe_clog2(DEPTH);
  logic [N_CH-1:0]  r_pend;
  logic [IDX_W-1:0] r_fifo [DEPTH];
  logic [PW-1:0]    r_wr, r_rd;
  logic [CW-1:0]    r_cnt;
  logic             w_gnt_vld, w_pop, w_spur, w_ovr;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [N_CH-1:0]  w_gnt_oh;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  conf_merge_arb #(.N_CH(N_CH)) u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (r_pend),
    .i_en     (r_cnt < CW'(DEPTH)),
    .i_mode   (ARB_MODE == ARB_RR),
    .o_gnt_vld(w_gnt_vld),
    .o_gnt_idx(w_gnt_idx)
  );
  assign w_gnt_oh = w_gnt_vld ? (N_CH'(1) << w_gnt_idx) : '0;
  assign w_pop    = i_freeNext & (r_cnt != '0);
  assign w_spur   = i_freeNext & (r_cnt == '0);
  assign w_ovr    = |(i_drive & r_pend & ~w_gnt_oh);
  assign o_busy   = r_cnt != '0;
  // pending set, owner FIFO, outstanding count and registered handshake outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_pend <= '0;
      for (int k = 0; k < DEPTH; k++) r_fifo[k] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_cnt <= '0;
      o_free <= '0;
      o_driveNext <= 1'b0;
      o_sel <= '0;
      o_err_overrun <= 1'b0;
      o_err_spurious <= 1'b0;
    end else begin
      r_pend <= (r_pend & ~w_gnt_oh) | i_drive;
      if (w_gnt_vld) begin
        r_fifo[r_wr] <= w_gnt_idx;
        r_wr <= nxt(r_wr);
        o_sel <= w_gnt_idx;
      end
      if (w_pop) r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(w_gnt_vld) - CW'(w_pop);
      o_free <= w_pop ? (N_CH'(1) << r_fifo[r_rd]) : '0;
      o_driveNext <= w_gnt_vld;
      o_err_overrun <= o_err_overrun | w_ovr;
      o_err_spurious <= o_err_spurious | w_spur;
    end
endmodule

// File: tb/tb_conf_merge_n.sv
// tb_conf_merge_n: directed checks of conf_merge_n in RR/DEPTH=2, RR/DEPTH=8 and fixed/DEPTH=8 builds
module tb_conf_merge_n;
  logic clk = 1'b0, rst_n = 1'b0, i_freeNext = 1'b0;
  logic [3:0] i_drive = '0;
  logic [3:0] a_free, b_free, c_free;
  logic a_drv, b_drv, c_drv, a_busy, b_busy, c_busy;
  logic [1:0] a_sel, b_sel, c_sel;
  logic a_ovr, b_ovr, c_ovr, a_spu, b_spu, c_spu;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  conf_merge_n #(.N_CH(4), .DEPTH(2), .ARB_MODE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_drive(i_drive), .o_free(a_free), .o_driveNext(a_drv),
    .o_sel(a_sel), .i_freeNext(i_freeNext), .o_busy(a_busy), .o_err_overrun(a_ovr), .o_err_spurious(a_spu));
  conf_merge_n #(.N_CH(4), .DEPTH(8), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst_n(rst_n), .i_drive(i_drive), .o_free(b_free), .o_driveNext(b_drv),
    .o_sel(b_sel), .i_freeNext(i_freeNext), .o_busy(b_busy), .o_err_overrun(b_ovr), .o_err_spurious(b_spu));
  conf_merge_n #(.N_CH(4), .DEPTH(8), .ARB_MODE(0)) u_fix (
    .clk(clk), .rst_n(rst_n), .i_drive(i_drive), .o_free(c_free), .o_driveNext(c_drv),
    .o_sel(c_sel), .i_freeNext(i_freeNext), .o_busy(c_busy), .o_err_overrun(c_ovr), .o_err_spurious(c_spu));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic step(input logic [3:0] d, input logic f);
    i_drive = d;
    i_freeNext = f;
    @(posedge clk);
    #1;
    i_drive = '0;
    i_freeNext = 1'b0;
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_drv", a_drv, 0);
    chk("rst_sel", a_sel, 0);
    chk("rst_free", a_free, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_ovr", a_ovr, 0);
    chk("rst_spu", a_spu, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    int n;
    @(posedge clk);
    #1;
    do_reset();
    step(4'b0100, 1'b0);
    chk("single_lat1", a_drv, 0);
    step('0, 1'b0);
    chk("single_drv", a_drv, 1);
    chk("single_sel", a_sel, 2);
    step('0, 1'b0);
    chk("single_drv_pulse", a_drv, 0);
    chk("single_busy3", a_busy, 1);
    step('0, 1'b0);
    chk("single_busy4", a_busy, 1);
    step('0, 1'b0);
    chk("single_busy5", a_busy, 1);
    step('0, 1'b1);
    chk("single_free", a_free, 4'b0100);
    step('0, 1'b0);
    chk("single_free_pulse", a_free, 0);
    chk("single_idle", a_busy, 0);
    chk("single_no_err", a_ovr | a_spu, 0);
    do_reset();
    step(4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step('0, 1'b0);
      chk("rr1_drv", b_drv, 1);
      chk("rr1_sel", b_sel, k);
    end
    step('0, 1'b0);
    chk("rr1_end", b_drv, 0);
    for (int k = 0; k < 4; k++) step('0, 1'b1);
    step(4'b0100, 1'b0);
    step('0, 1'b0);
    chk("rr2_pre_sel", b_sel, 2);
    step(4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) begin
      step('0, 1'b0);
      chk("rr2_drv", b_drv, 1);
      chk("rr2_sel", b_sel, (3 + k) % 4);
    end
    do_reset();
    step(4'b0100, 1'b0);
    step('0, 1'b0);
    step(4'b1010, 1'b0);
    step('0, 1'b0);
    chk("fix_sel1", c_sel, 1);
    chk("rrcmp_sel1", b_sel, 3);
    step('0, 1'b0);
    chk("fix_sel2", c_sel, 3);
    chk("rrcmp_sel2", b_sel, 1);
    do_reset();
    step(4'b0111, 1'b0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step('0, 1'b0);
      n += int'(a_drv);
    end
    chk("bp_two", n, 2);
    step('0, 1'b1);
    chk("bp_free0", a_free, 4'b0001);
    chk("bp_not_yet", a_drv, 0);
    step('0, 1'b0);
    chk("bp_third", a_drv, 1);
    chk("bp_third_sel", a_sel, 2);
    step('0, 1'b1);
    chk("bp_free1", a_free, 4'b0010);
    step('0, 1'b1);
    chk("bp_free2", a_free, 4'b0100);
    do_reset();
    step(4'b0110, 1'b0);
    step('0, 1'b0);
    step(4'b0001, 1'b0);
    chk("ovr_clear", a_ovr, 0);
    step(4'b0001, 1'b0);
    chk("ovr_set", a_ovr, 1);
    step('0, 1'b1);
    chk("ovr_free", a_free, 4'b0010);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      step('0, 1'b0);
      n += int'(a_drv && a_sel == 2'd0);
    end
    chk("ovr_one_grant", n, 1);
    chk("ovr_sticky", a_ovr, 1);
    do_reset();
    step(4'b0010, 1'b0);
    step(4'b0010, 1'b0);
    chk("same_drv1", a_drv, 1);
    chk("same_sel1", a_sel, 1);
    step('0, 1'b0);
    chk("same_drv2", a_drv, 1);
    chk("same_sel2", a_sel, 1);
    chk("same_no_ovr", a_ovr, 0);
    do_reset();
    step('0, 1'b1);
    chk("spur_flag", a_spu, 1);
    chk("spur_free", a_free, 0);
    chk("spur_busy", a_busy, 0);
    do_reset();
    step(4'b0011, 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);
    chk("mid_sel", a_sel, 1);
    chk("mid_busy", a_busy, 1);
    do_reset();
    step('0, 1'b1);
    chk("mid_spur", a_spu, 1);
    chk("mid_free", a_free, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
